// File: rtl/pkt_bufm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pkt_bufm_pkg
// Description : Shared sizing constants and the free-pool strobe record used by
//               the packet-buffer manager and the free-buffer FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package pkt_bufm_pkg;

    localparam int BUFID_W = 9;
    localparam int CNT_W   = 4;

    // Record pushed into the free-buffer FIFO when a buffer is released.
    typedef struct packed {
        logic [BUFID_W-1:0] bufid;
        logic               wr;
    } free_strobe_t;

endpackage : pkt_bufm_pkg
`default_nettype wire

// File: rtl/refcnt_array.sv
`default_nettype none
// ============================================================================
// Module      : refcnt_array
// Description : Reference-count register file, one async read port, one sync
//               write port, synchronous clear of every entry on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module refcnt_array #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_raddr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

endmodule : refcnt_array
`default_nettype wire

// File: rtl/pkt_bufid_refcnt_manager.sv
`default_nettype none
// ============================================================================
// Module      : pkt_bufid_refcnt_manager
// Description : Per-buffer reference counting; returns buffers to the free
//               pool when their count reaches zero and flags misuse.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_bufid_refcnt_manager
    import pkt_bufm_pkg::*;
#(
    parameter int BUFID_W = pkt_bufm_pkg::BUFID_W,
    parameter int CNT_W   = pkt_bufm_pkg::CNT_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [BUFID_W-1:0] iv_pkt_bufid,
    input  logic [CNT_W-1:0]   iv_pkt_bufid_cnt,
    input  logic               i_pkt_bufid_wr,
    input  logic [BUFID_W-1:0] iv_release_bufid,
    input  logic               i_release_wr,
    output logic               o_release_ack,
    output logic [BUFID_W-1:0] ov_free_bufid,
    output logic               o_free_bufid_wr,
    output logic [BUFID_W:0]   ov_inuse_cnt,
    output logic               o_err_underflow,
    output logic               o_err_overwrite
);

    logic               w_set;
    logic               w_rel;
    logic [BUFID_W-1:0] w_addr;
    logic [CNT_W-1:0]   w_old;
    logic [CNT_W-1:0]   w_wdata;
    logic               w_we;
    logic               w_old_zero;
    logic               w_old_one;
    logic               w_free;
    logic               w_inc;
    logic               w_dec;

    logic [BUFID_W-1:0] r_free_bufid;
    logic               r_free_wr;
    logic [BUFID_W:0]   r_inuse_cnt;
    logic               r_err_underflow;
    logic               r_err_overwrite;

    // Sets win the single array port; a pending release simply waits.
    assign w_set         = i_pkt_bufid_wr;
    assign w_rel         = i_release_wr & ~i_pkt_bufid_wr;
    assign o_release_ack = w_rel;
    assign w_addr        = w_set ? iv_pkt_bufid : iv_release_bufid;

    refcnt_array #(
        .ADDR_W (BUFID_W),
        .DATA_W (CNT_W)
    ) u_refcnt_array (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_raddr (w_addr),
        .o_rdata (w_old),
        .i_we    (w_we),
        .i_waddr (w_addr),
        .i_wdata (w_wdata)
    );

    assign w_old_zero = (w_old == '0);
    assign w_old_one  = (w_old == CNT_W'(1));

    always_comb begin
        w_we    = 1'b0;
        w_wdata = w_old;
        if (w_set) begin
            w_we    = 1'b1;
            w_wdata = iv_pkt_bufid_cnt;
        end else if (w_rel && !w_old_zero) begin
            w_we    = 1'b1;
            w_wdata = w_old - CNT_W'(1);
        end
    end

    // Overwrite of a live buffer leaves occupancy alone, even with a zero count.
    assign w_free = (w_set & (iv_pkt_bufid_cnt == '0)) | (w_rel & w_old_one);
    assign w_inc  = w_set & w_old_zero & (iv_pkt_bufid_cnt != '0);
    assign w_dec  = w_rel & w_old_one;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_free_bufid    <= '0;
            r_free_wr       <= 1'b0;
            r_inuse_cnt     <= '0;
            r_err_underflow <= 1'b0;
            r_err_overwrite <= 1'b0;
        end else begin
            r_free_wr       <= w_free;
            r_err_underflow <= w_rel & w_old_zero;
            r_err_overwrite <= w_set & ~w_old_zero;
            if (w_free) begin
                r_free_bufid <= w_addr;
            end
            if (w_inc) begin
                r_inuse_cnt <= r_inuse_cnt + 1'b1;
            end else if (w_dec) begin
                r_inuse_cnt <= r_inuse_cnt - 1'b1;
            end
        end
    end

    assign ov_free_bufid   = r_free_bufid;
    assign o_free_bufid_wr = r_free_wr;
    assign ov_inuse_cnt    = r_inuse_cnt;
    assign o_err_underflow = r_err_underflow;
    assign o_err_overwrite = r_err_overwrite;

endmodule : pkt_bufid_refcnt_manager
`default_nettype wire

// File: tb/tb_pkt_bufid_refcnt_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_pkt_bufid_refcnt_manager
// Description : Directed scenarios plus randomized traffic against a
//               behavioural reference-count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_bufid_refcnt_manager;

    localparam int BW = 9;
    localparam int CW = 4;
    localparam int NB = 2 ** BW;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] pkt_bufid;
    logic [CW-1:0] pkt_cnt;
    logic          pkt_wr;
    logic [BW-1:0] rel_bufid;
    logic          rel_wr;
    logic          release_ack;
    logic [BW-1:0] free_bufid;
    logic          free_wr;
    logic [BW:0]   inuse_cnt;
    logic          err_under;
    logic          err_over;

    pkt_bufid_refcnt_manager #(.BUFID_W(BW), .CNT_W(CW)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .iv_pkt_bufid     (pkt_bufid),
        .iv_pkt_bufid_cnt (pkt_cnt),
        .i_pkt_bufid_wr   (pkt_wr),
        .iv_release_bufid (rel_bufid),
        .i_release_wr     (rel_wr),
        .o_release_ack    (release_ack),
        .ov_free_bufid    (free_bufid),
        .o_free_bufid_wr  (free_wr),
        .ov_inuse_cnt     (inuse_cnt),
        .o_err_underflow  (err_under),
        .o_err_overwrite  (err_over)
    );

    always #4 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: plain array of counts and an occupancy integer.
    int          m_cnt [NB];
    int          m_inuse;
    int          m_free_bufid;
    logic        m_free_wr;
    logic        m_under;
    logic        m_over;
    logic        m_ack;
    logic        act_ack;

    task automatic model_edge();
        m_free_wr = 1'b0;
        m_under   = 1'b0;
        m_over    = 1'b0;
        if (rst) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_inuse      = 0;
            m_free_bufid = 0;
        end else if (pkt_wr) begin
            if (m_cnt[pkt_bufid] != 0) m_over = 1'b1;
            else if (pkt_cnt != 0)     m_inuse = m_inuse + 1;
            if (pkt_cnt == 0) begin
                m_free_wr    = 1'b1;
                m_free_bufid = int'(pkt_bufid);
            end
            m_cnt[pkt_bufid] = int'(pkt_cnt);
        end else if (rel_wr) begin
            if (m_cnt[rel_bufid] == 0) begin
                m_under = 1'b1;
            end else begin
                m_cnt[rel_bufid] = m_cnt[rel_bufid] - 1;
                if (m_cnt[rel_bufid] == 0) begin
                    m_free_wr    = 1'b1;
                    m_free_bufid = int'(rel_bufid);
                    m_inuse      = m_inuse - 1;
                end
            end
        end
    endtask

    // Inputs are applied 1 time unit after a rising edge; ack is sampled mid-cycle.
    task automatic drive(input logic s, input int sid, input int sc,
                         input logic r, input int rid);
        pkt_wr    = s;
        pkt_bufid = BW'(sid);
        pkt_cnt   = CW'(sc);
        rel_wr    = r;
        rel_bufid = BW'(rid);
        #2;
        act_ack = release_ack;
        m_ack   = r & ~s;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 1'b0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 0, 0, 1'b0, 0);
        drive(1'b0, 0, 0, 1'b0, 0);
        checks++;
        if (inuse_cnt !== '0 || free_wr !== 1'b0 || free_bufid !== '0 ||
            err_under !== 1'b0 || err_over !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: inuse=%0d free_wr=%b free_id=%0d under=%b over=%b, want all 0",
                     inuse_cnt, free_wr, free_bufid, err_under, err_over);
        end
        checks++;
        if (act_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_ack: ack=%b want 0", act_ack);
        end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_release_chain();
        int frees = 0;
        drive(1'b1, 5, 3, 1'b0, 0);
        checks++;
        if (inuse_cnt !== 10'd1) begin
            errors++;
            $display("FAIL chain_inuse_set: inuse=%0d want 1", inuse_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 0, 0, 1'b1, 5);
            checks++;
            if (act_ack !== 1'b1) begin
                errors++;
                $display("FAIL chain_ack%0d: ack=%b want 1", k, act_ack);
            end
            if (free_wr === 1'b1) frees++;
        end
        checks++;
        if (frees != 1 || free_wr !== 1'b1 || free_bufid !== 9'd5 || inuse_cnt !== 10'd0) begin
            errors++;
            $display("FAIL chain_free: frees=%0d last_wr=%b id=%0d inuse=%0d want 1/1/5/0",
                     frees, free_wr, free_bufid, inuse_cnt);
        end
        idle();
        checks++;
        if (free_wr !== 1'b0) begin
            errors++;
            $display("FAIL chain_free_pulse: free_wr=%b want 0", free_wr);
        end
    endtask

    task automatic test_zero_count_set();
        drive(1'b1, 7, 0, 1'b0, 0);
        checks++;
        if (free_wr !== 1'b1 || free_bufid !== 9'd7 || inuse_cnt !== 10'd0 ||
            err_over !== 1'b0 || err_under !== 1'b0) begin
            errors++;
            $display("FAIL zero_set: wr=%b id=%0d inuse=%0d over=%b under=%b want 1/7/0/0/0",
                     free_wr, free_bufid, inuse_cnt, err_over, err_under);
        end
        idle();
    endtask

    task automatic test_underflow();
        drive(1'b0, 0, 0, 1'b1, 9);
        checks++;
        if (err_under !== 1'b1 || free_wr !== 1'b0 || inuse_cnt !== 10'd0) begin
            errors++;
            $display("FAIL underflow: under=%b free_wr=%b inuse=%0d want 1/0/0",
                     err_under, free_wr, inuse_cnt);
        end
        idle();
        checks++;
        if (err_under !== 1'b0) begin
            errors++;
            $display("FAIL underflow_pulse: under=%b want 0", err_under);
        end
    endtask

    task automatic test_overwrite();
        drive(1'b1, 2, 2, 1'b0, 0);
        drive(1'b1, 2, 2, 1'b0, 0);
        checks++;
        if (err_over !== 1'b1 || inuse_cnt !== 10'd1) begin
            errors++;
            $display("FAIL overwrite: over=%b inuse=%0d want 1/1", err_over, inuse_cnt);
        end
        drive(1'b0, 0, 0, 1'b1, 2);
        checks++;
        if (free_wr !== 1'b0 || err_over !== 1'b0) begin
            errors++;
            $display("FAIL overwrite_rel1: free_wr=%b over=%b want 0/0", free_wr, err_over);
        end
        drive(1'b0, 0, 0, 1'b1, 2);
        checks++;
        if (free_wr !== 1'b1 || free_bufid !== 9'd2 || inuse_cnt !== 10'd0) begin
            errors++;
            $display("FAIL overwrite_rel2: wr=%b id=%0d inuse=%0d want 1/2/0",
                     free_wr, free_bufid, inuse_cnt);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 20, 1, 1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 30 + k, k + 1, 1'b1, 20);
            checks++;
            if (act_ack !== 1'b0) begin
                errors++;
                $display("FAIL b2b_stall%0d: ack=%b want 0", k, act_ack);
            end
        end
        drive(1'b0, 0, 0, 1'b1, 20);
        checks++;
        if (act_ack !== 1'b1 || free_wr !== 1'b1 || free_bufid !== 9'd20 || inuse_cnt !== 10'd4) begin
            errors++;
            $display("FAIL b2b_accept: ack=%b wr=%b id=%0d inuse=%0d want 1/1/20/4",
                     act_ack, free_wr, free_bufid, inuse_cnt);
        end
        // Buffer 30+k was set with k+1 references: exactly k+1 releases free it.
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j <= k; j++) drive(1'b0, 0, 0, 1'b1, 30 + k);
            checks++;
            if (free_wr !== 1'b1 || free_bufid !== BW'(30 + k) || inuse_cnt !== 10'(3 - k)) begin
                errors++;
                $display("FAIL b2b_drain%0d: wr=%b id=%0d inuse=%0d want 1/%0d/%0d",
                         k, free_wr, free_bufid, inuse_cnt, 30 + k, 3 - k);
            end
        end
        idle();
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 40, 2, 1'b0, 0);
        drive(1'b1, 41, 1, 1'b0, 0);
        drive(1'b1, 42, 3, 1'b0, 0);
        checks++;
        if (inuse_cnt !== 10'd3) begin
            errors++;
            $display("FAIL mid_live: inuse=%0d want 3", inuse_cnt);
        end
        rst = 1'b1;
        drive(1'b0, 0, 0, 1'b1, 41);
        rst = 1'b0;
        checks++;
        if (inuse_cnt !== '0 || free_wr !== 1'b0 || free_bufid !== '0 ||
            err_under !== 1'b0 || err_over !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: inuse=%0d wr=%b id=%0d under=%b over=%b want all 0",
                     inuse_cnt, free_wr, free_bufid, err_under, err_over);
        end
        drive(1'b0, 0, 0, 1'b1, 41);
        checks++;
        if (err_under !== 1'b1 || free_wr !== 1'b0) begin
            errors++;
            $display("FAIL mid_underflow: under=%b free_wr=%b want 1/0", err_under, free_wr);
        end
        idle();
    endtask

    task automatic test_random();
        logic s, r;
        int   sid, sc, rid;
        rst = 1'b1;
        idle();
        rst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            s   = ($urandom_range(0, 9) < 3);
            r   = ($urandom_range(0, 9) < 6);
            sid = $urandom_range(0, 7);
            rid = $urandom_range(0, 7);
            // Zero-count sets only target idle buffers so occupancy stays meaningful.
            sc  = (m_cnt[sid] == 0) ? $urandom_range(0, 3) : $urandom_range(1, 3);
            drive(s, sid, sc, r, rid);
            checks++;
            if (act_ack !== m_ack || free_wr !== m_free_wr || err_under !== m_under ||
                err_over !== m_over || inuse_cnt !== (BW+1)'(m_inuse) ||
                free_bufid !== BW'(m_free_bufid)) begin
                errors++;
                $display("FAIL random[%0d]: ack=%b wr=%b id=%0d under=%b over=%b inuse=%0d want %b/%b/%0d/%b/%b/%0d",
                         n, act_ack, free_wr, free_bufid, err_under, err_over, inuse_cnt,
                         m_ack, m_free_wr, m_free_bufid, m_under, m_over, m_inuse);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        pkt_wr    = 1'b0;
        pkt_bufid = '0;
        pkt_cnt   = '0;
        rel_wr    = 1'b0;
        rel_bufid = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_release_chain();
        test_zero_count_set();
        test_underflow();
        test_overwrite();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pkt_bufid_refcnt_manager
`default_nettype wire

// File: doc/pkt_bufid_refcnt_manager.md
# pkt_bufid_refcnt_manager

Receiving end of the forwarding stage's buffer-reference report (pkt_bufid + fan-out count), sitting in the centralized packet-buffer memory block. Keeps one reference counter per packet buffer. Decrements the counter each time an output port or host path finishes with the buffer, and returns the buffer id to the free-buffer pool when the count reaches zero. Flags protocol violations (underflow, overwrite of a live buffer) and reports buffer occupancy.

## Interface
Parameters:
- BUFID_W, 9, packet buffer id width (2^BUFID_W buffers)
- CNT_W, 4, reference-count width

Ports:
- i_clk  in  1  125 MHz clock, the block's only clock
- i_rst  in  1  synchronous, active-high reset
- iv_pkt_bufid  in  BUFID_W  buffer id reported by forwarding
- iv_pkt_bufid_cnt  in  CNT_W  number of destinations for that buffer
- i_pkt_bufid_wr  in  1  one-cycle strobe; always accepted, no ack
- iv_release_bufid  in  BUFID_W  buffer id whose transmission finished (pre-arbitrated tx-side stream)
- i_release_wr  in  1  release request; held with bufid until ack
- o_release_ack  out  1  combinational accept for the current release request
- ov_free_bufid  out  BUFID_W  buffer id returned to the free pool
- o_free_bufid_wr  out  1  one-cycle strobe for ov_free_bufid
- ov_inuse_cnt  out  BUFID_W+1  number of buffers with nonzero count
- o_err_underflow  out  1  one-cycle pulse: release hit a zero count
- o_err_overwrite  out  1  one-cycle pulse: set hit a nonzero count

## Operation
- Counter array cnt[0..2^BUFID_W-1], each CNT_W bits, all zero after reset.
- Set (i_pkt_bufid_wr=1) has priority. On the edge, cnt[bufid] is written with iv_pkt_bufid_cnt.
  - If the old count was nonzero, pulse o_err_overwrite. The new value is still written and ov_inuse_cnt is unchanged.
  - If iv_pkt_bufid_cnt=0, the buffer is freed immediately: free strobe for bufid, counter stays 0.
  - Otherwise ov_inuse_cnt increments, provided the old count was 0.
- Release: o_release_ack = i_release_wr & ~i_pkt_bufid_wr. A release is never processed in the same cycle as a set, so at most one free happens per cycle. Accepted releases act on cnt[release_bufid]:
  - 0: pulse o_err_underflow; the count stays 0; no free.
  - 1: write 0, emit a free for the bufid, decrement ov_inuse_cnt.
  - >1: decrement the count.
- Counts saturate at neither end; a count above 2^CNT_W-1 is impossible by construction.

## Timing
- Reset values: all counters 0, ov_free_bufid=0, o_free_bufid_wr=0, ov_inuse_cnt=0, both error flags 0. o_release_ack follows its inputs, so it is 0 while i_release_wr=0.
- A reset in mid-operation clears all counters and the occupancy count within the reset cycle. Pending requests are dropped; upstream must re-present them after reset.
- Latency: a set or release sampled at edge N produces the free strobe, error pulse and ov_inuse_cnt update as registered outputs visible after edge N (one-cycle latency).
- The counter read is combinational from the array at the sampling edge. A request to the same bufid on consecutive cycles must see the updated value, so there are no read hazards.
- Release stream: upstream holds i_release_wr and the bufid until a cycle with o_release_ack=1. Under back-to-back sets the release stalls for as many cycles as there are consecutive sets.
- Throughput: one operation per cycle. A set and a release can never complete in the same cycle.

## Structure
- Shared package pkt_bufm_pkg holds BUFID_W, CNT_W and the free-pool strobe record (bufid + wr), which is shared with the free-buffer FIFO.
- One sub-module, refcnt_array: 2^BUFID_W x CNT_W register file with one asynchronous read port, one synchronous write port and a synchronous clear on i_rst.
- The top level holds the request mux, the decision logic, the occupancy counter and the output registers.

## Test plan
- Set bufid 5 with cnt 3, then three releases of 5 → acks on each; exactly one free strobe, ov_free_bufid=5, one cycle after the third release. ov_inuse_cnt goes 0→1→0.
- Set bufid 7 with cnt 0 → free strobe with bufid 7 one cycle later; ov_inuse_cnt stays 0; no error.
- Release bufid 9 with no prior set → o_err_underflow pulse one cycle later; no free; count stays 0.
- Set bufid 2 with cnt 2 twice → second set gives an o_err_overwrite pulse; ov_inuse_cnt=1; two releases then free bufid 2.
- Release held during 4 back-to-back sets → o_release_ack is 0 for those 4 cycles and 1 in the 5th; all counts are correct afterwards.
- Assert i_rst with 3 live buffers → next cycle ov_inuse_cnt=0 and all outputs 0; a subsequent release of a previously live bufid gives an underflow pulse.
